// File: rtl/sample_dumper.sv
// sample_dumper: reads DEPTH samples from the sample memory and sends them
// to uart_tx as one frame: HEADER, DEPTH sample bytes, optional checksum.
// Optional feature macro: SAMPLE_DUMP_CKSUM_EN (appends an 8-bit sum byte).
//
// UART handshake: tx_start is a one-cycle strobe raised only while tx_active
// is low. After a strobe the FSM parks in a *_W state until the one-cycle
// tx_done pulse, so at most one byte is in flight. tx_done seen in any other
// state belongs to another UART client and is ignored.
module sample_dumper #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [7:0]            HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_active,
    input  logic                  tx_done,
    output logic [3:0]            dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

`ifdef SAMPLE_DUMP_CKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR    = 4'd1,
        S_HDR_W  = 4'd2,
        S_FETCH  = 4'd3,
        S_SEND   = 4'd4,
        S_SEND_W = 4'd5,
        S_CK     = 4'd6,
        S_CK_W   = 4'd7,
        S_FIN    = 4'd8
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR    = 4'd1,
        S_HDR_W  = 4'd2,
        S_FETCH  = 4'd3,
        S_SEND   = 4'd4,
        S_SEND_W = 4'd5,
        S_FIN    = 4'd8
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              tx_data_q, tx_data_d;
`ifdef SAMPLE_DUMP_CKSUM_EN
    logic [7:0]              cksum_q, cksum_d;
`endif

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            addr_q    <= START_ADDR;
            tx_data_q <= '0;
`ifdef SAMPLE_DUMP_CKSUM_EN
            cksum_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
`ifdef SAMPLE_DUMP_CKSUM_EN
            cksum_q   <= cksum_d;
`endif
        end
    end

    // Next-state logic plus the strobes (tx_start, mem_oe) decoded from state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        tx_data_d = tx_data_q;
`ifdef SAMPLE_DUMP_CKSUM_EN
        cksum_d   = cksum_q;
`endif
        tx_start  = 1'b0;
        mem_oe    = 1'b0;

        if (state_q != S_IDLE && !activate) begin
            // Release/abort: a byte already inside uart_tx finishes on its own.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (activate) begin
                        state_d   = S_HDR;
                        count_d   = '0;
                        addr_d    = START_ADDR;
                        tx_data_d = HEADER;
`ifdef SAMPLE_DUMP_CKSUM_EN
                        cksum_d   = '0;
`endif
                    end
                end
                S_HDR: begin
                    if (!tx_active) begin
                        tx_start = 1'b1;
                        state_d  = S_HDR_W;
                    end
                end
                S_HDR_W: begin
                    if (tx_done) state_d = S_FETCH;
                end
                S_FETCH: begin
                    mem_oe    = 1'b1;
                    tx_data_d = mem_data;
`ifdef SAMPLE_DUMP_CKSUM_EN
                    cksum_d   = cksum_q + mem_data;
`endif
                    state_d   = S_SEND;
                end
                S_SEND: begin
                    if (!tx_active) begin
                        tx_start = 1'b1;
                        state_d  = S_SEND_W;
                    end
                end
                S_SEND_W: begin
                    if (tx_done) begin
                        count_d = count_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        if (count_q + 1'b1 == CW'(DEPTH)) begin
`ifdef SAMPLE_DUMP_CKSUM_EN
                            tx_data_d = cksum_q;
                            state_d   = S_CK;
`else
                            state_d   = S_FIN;
`endif
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
`ifdef SAMPLE_DUMP_CKSUM_EN
                S_CK: begin
                    if (!tx_active) begin
                        tx_start = 1'b1;
                        state_d  = S_CK_W;
                    end
                end
                S_CK_W: begin
                    if (tx_done) state_d = S_FIN;
                end
`endif
                S_FIN: begin
                    state_d = S_FIN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        done      = (state_q == S_FIN);
        mem_addr  = addr_q;
        tx_data   = tx_data_q;
        dbg_state = state_q;
    end

endmodule
